fib_dispatch: RTL and testbench

FIB_DISPATCH -- requirements
Module: fib_dispatch

---
 rtl/fib_dispatch_pkg.sv | 31 +++
 rtl/fib_req_fifo.sv | 74 +++++++
 rtl/fib_dispatch.sv | 135 +++++++++++++
 tb/tb_fib_dispatch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_dispatch_pkg
// Description : Shared widths, FSM encoding and job record for fib_dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_dispatch_pkg;

    localparam int N_W = 6;
    localparam int D_W = 32;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_START = 2'd1;
    localparam logic [1:0] C_ST_RUN   = 2'd2;
    localparam logic [1:0] C_ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_START = C_ST_START,
        ST_RUN   = C_ST_RUN,
        ST_HOLD  = C_ST_HOLD
    } fib_state_e;

    typedef struct packed {
        logic [N_W-1:0] n;
        logic [D_W-1:0] a;
        logic [D_W-1:0] b;
    } fib_job_t;

endpackage
`default_nettype wire

// File: rtl/fib_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fib_req_fifo
// Description : Power-of-two deep FIFO of pending fib jobs with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_req_fifo
    import fib_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  fib_job_t               i_push_data,
    input  logic                   i_pop,
    output fib_job_t               o_pop_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    fib_job_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == C_DEPTH);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

`ifndef SYNTHESIS
    a_count_bound : assert property (@(posedge clk) disable iff (rst) r_count <= C_DEPTH);
`endif

endmodule
`default_nettype wire

// File: rtl/fib_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : fib_dispatch
// Description : Queues fib jobs, launches them on a downstream core one at a
//               time and returns results (or a timeout) in acceptance order.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_dispatch
    import fib_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [N_W-1:0] req_n,
    input  logic [D_W-1:0] req_a,
    input  logic [D_W-1:0] req_b,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [D_W-1:0] resp_data,
    output logic           resp_timeout,
    output logic           core_r_enable,
    output logic [N_W-1:0] core_init_n,
    output logic [D_W-1:0] core_init_a,
    output logic [D_W-1:0] core_init_b,
    input  logic           core_w_enable,
    input  logic [D_W-1:0] core_result,
    output logic           busy
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    fib_state_e       r_state;
    fib_job_t         r_job;
    logic [TIMER_W-1:0] r_timer;
    logic [D_W-1:0]   r_resp_data;
    logic             r_resp_timeout;

    fib_job_t         w_req_job;
    fib_job_t         w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;

    assign w_req_job = '{n: req_n, a: req_a, b: req_b};
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == ST_IDLE) && !w_fifo_empty;

    fib_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_req_job),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Job registers change only when a job is popped, so the core's init
    // operands stay stable for the whole START/RUN span.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_job          <= '0;
            r_timer        <= '0;
            r_resp_data    <= '0;
            r_resp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_job   <= w_head;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_timer <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // Completion takes priority over a coincident timeout.
                    if (core_w_enable) begin
                        r_resp_data    <= core_result;
                        r_resp_timeout <= 1'b0;
                        r_state        <= ST_HOLD;
                    end else if (r_timer == C_TIMER_LAST) begin
                        r_resp_data    <= '0;
                        r_resp_timeout <= 1'b1;
                        r_state        <= ST_HOLD;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = !rst && !w_fifo_full;
    assign resp_valid    = !rst && (r_state == ST_HOLD);
    assign resp_data     = r_resp_data;
    assign resp_timeout  = r_resp_timeout;
    assign busy          = !rst && ((r_state != ST_IDLE) || (w_fifo_count != '0));

    // The core treats r_enable as its load/clear strobe, so it is held during reset.
    assign core_r_enable = rst || (r_state == ST_START);
    assign core_init_n   = r_job.n;
    assign core_init_a   = r_job.a;
    assign core_init_b   = r_job.b;

`ifndef SYNTHESIS
    a_resp_hold : assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_data) && $stable(resp_timeout)));
    a_start_one : assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_START) |=> (r_state == ST_RUN));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fib_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_dispatch
// Description : Directed bench for fib_dispatch with a behavioural fib core
//               and a second instance on a never-finishing core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (default timeout) wired to the behavioural core
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_timeout;
    logic [5:0]  req_n, core_init_n;
    logic [31:0] req_a, req_b, resp_data, core_init_a, core_init_b, core_result;
    logic        core_r_enable, core_w_enable, busy;

    // Timeout instance wired to a core that never completes
    logic        to_req_valid, to_req_ready, to_resp_valid, to_resp_ready, to_resp_timeout;
    logic [5:0]  to_req_n, to_core_init_n;
    logic [31:0] to_req_a, to_req_b, to_resp_data, to_core_init_a, to_core_init_b;
    logic        to_core_r_enable, to_busy;
    logic        to_core_w_enable = 1'b0;
    logic [31:0] to_core_result   = 32'hDEAD_BEEF;

    int n_vec = 0;
    int n_err = 0;

    fib_dispatch #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(1024)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_n(req_n), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_timeout(resp_timeout),
        .core_r_enable(core_r_enable), .core_init_n(core_init_n),
        .core_init_a(core_init_a), .core_init_b(core_init_b),
        .core_w_enable(core_w_enable), .core_result(core_result),
        .busy(busy)
    );

    fib_dispatch #(.FIFO_DEPTH(2), .TIMEOUT_CYCLES(16)) u_dut_to (
        .clk(clk), .rst(rst),
        .req_valid(to_req_valid), .req_ready(to_req_ready),
        .req_n(to_req_n), .req_a(to_req_a), .req_b(to_req_b),
        .resp_valid(to_resp_valid), .resp_ready(to_resp_ready),
        .resp_data(to_resp_data), .resp_timeout(to_resp_timeout),
        .core_r_enable(to_core_r_enable), .core_init_n(to_core_init_n),
        .core_init_a(to_core_init_a), .core_init_b(to_core_init_b),
        .core_w_enable(to_core_w_enable), .core_result(to_core_result),
        .busy(to_busy)
    );

    // Behavioural core: (a,b) -> (a+b,a) n times, sticky done until next load
    logic [5:0]  cm_n;
    logic [31:0] cm_a, cm_b;
    logic        cm_done;
    always @(posedge clk) begin
        if (core_r_enable) begin
            cm_n    <= core_init_n;
            cm_a    <= core_init_a;
            cm_b    <= core_init_b;
            cm_done <= 1'b0;
        end else if (!cm_done) begin
            if (cm_n == 6'd0) begin
                cm_done <= 1'b1;
            end else begin
                cm_a <= cm_a + cm_b;
                cm_b <= cm_a;
                cm_n <= cm_n - 6'd1;
            end
        end
    end
    assign core_result   = cm_a;
    assign core_w_enable = cm_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_vec++;
        if (obs !== expd) begin
            n_err++;
            $display("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, expd, expd);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!req_ready && guard < 300) begin
            tick;
            guard++;
        end
        chk("send_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_n     = n;
        req_a     = a;
        req_b     = b;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic get_resp(input string tag, input logic [31:0] ed, input logic eto);
        int guard = 0;
        resp_ready = 1'b1;
        while (!resp_valid && guard < 400) begin
            tick;
            guard++;
        end
        chk({tag, "_valid"}, 32'(resp_valid), 1);
        chk({tag, "_data"}, resp_data, ed);
        chk({tag, "_timeout"}, 32'(resp_timeout), 32'(eto));
        tick;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] b2b_exp [5];
        int guard;
        int early;
        int seen;
        int pulses;
        b2b_exp[0] = 1; b2b_exp[1] = 2; b2b_exp[2] = 3; b2b_exp[3] = 5; b2b_exp[4] = 8;

        req_valid = 1'b0; req_n = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        to_req_valid = 1'b0; to_req_n = '0; to_req_a = '0; to_req_b = '0; to_resp_ready = 1'b0;

        // Reset values
        repeat (3) tick;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_core_r_en", 32'(core_r_enable), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        rst = 1'b0;
        tick;
        chk("post_req_ready", 32'(req_ready), 1);
        chk("post_core_r_en", 32'(core_r_enable), 0);
        chk("post_resp_valid", 32'(resp_valid), 0);
        chk("post_resp_data", resp_data, 0);
        chk("post_resp_to", 32'(resp_timeout), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_init_n", 32'(core_init_n), 0);
        chk("post_init_a", core_init_a, 0);
        chk("post_init_b", core_init_b, 0);
        chk("post_to_ready", 32'(to_req_ready), 1);

        // Latency and n=10 result
        req_valid = 1'b1; req_n = 6'd10; req_a = 32'd1; req_b = 32'd0;
        tick;
        req_valid = 1'b0;
        chk("lat_t1_r_en", 32'(core_r_enable), 0);
        chk("lat_t1_busy", 32'(busy), 1);
        tick;
        chk("lat_t2_r_en", 32'(core_r_enable), 1);
        chk("lat_init_n", 32'(core_init_n), 10);
        chk("lat_init_a", core_init_a, 1);
        chk("lat_init_b", core_init_b, 0);
        tick;
        chk("lat_run_r_en", 32'(core_r_enable), 0);
        chk("lat_run_init_n", 32'(core_init_n), 10);
        guard = 0;
        while (!core_w_enable && guard < 100) begin
            tick;
            guard++;
        end
        chk("lat_done_seen", 32'(core_w_enable), 1);
        chk("lat_valid_early", 32'(resp_valid), 0);
        tick;
        chk("lat_valid", 32'(resp_valid), 1);
        chk("lat_data", resp_data, 89);
        chk("lat_timeout", 32'(resp_timeout), 0);
        resp_ready = 1'b1;
        tick;
        chk("lat_after_hs_valid", 32'(resp_valid), 0);
        chk("lat_after_hs_busy", 32'(busy), 0);

        // Operand corner cases
        send(6'd0, 32'd5, 32'd7);
        get_resp("n0", 32'd5, 1'b0);
        send(6'd47, 32'd1, 32'd0);
        get_resp("n47", 32'd512559680, 1'b0);

        // Back-to-back fill of a 4-deep queue
        resp_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send(6'(i), 32'd1, 32'd0);
        end
        chk("b2b_full_ready", 32'(req_ready), 0);
        chk("b2b_full_busy", 32'(busy), 1);
        for (int i = 0; i < 5; i++) begin
            get_resp($sformatf("b2b_%0d", i), b2b_exp[i], 1'b0);
        end

        // Stalled response with a job waiting in the queue
        resp_ready = 1'b0;
        send(6'd6, 32'd1, 32'd0);
        send(6'd2, 32'd1, 32'd0);
        guard = 0;
        while (!resp_valid && guard < 100) begin
            tick;
            guard++;
        end
        for (int k = 0; k < 20; k++) begin
            chk("hold_valid", 32'(resp_valid), 1);
            chk("hold_data", resp_data, 13);
            chk("hold_r_en", 32'(core_r_enable), 0);
            tick;
        end
        get_resp("hold_rel", 32'd13, 1'b0);
        get_resp("hold_next", 32'd2, 1'b0);

        // Timeout on the stalled core
        to_req_valid = 1'b1; to_req_n = 6'd3; to_req_a = 32'd9; to_req_b = 32'd9;
        tick;
        to_req_valid = 1'b0;
        tick;
        chk("to_start", 32'(to_core_r_enable), 1);
        tick;
        early = 0;
        repeat (16) begin
            if (to_resp_valid) early++;
            tick;
        end
        chk("to_early_valid", 32'(early), 0);
        chk("to_valid", 32'(to_resp_valid), 1);
        chk("to_data", to_resp_data, 0);
        chk("to_flag", 32'(to_resp_timeout), 1);
        tick;
        chk("to_still_valid", 32'(to_resp_valid), 1);
        to_resp_ready = 1'b1;
        tick;
        chk("to_after_hs", 32'(to_resp_valid), 0);

        // Reset in RUN with two jobs queued
        resp_ready = 1'b1;
        send(6'd40, 32'd1, 32'd0);
        send(6'd3, 32'd1, 32'd0);
        send(6'd4, 32'd1, 32'd0);
        tick;
        tick;
        chk("mid_pre_busy", 32'(busy), 1);
        rst = 1'b1;
        tick;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(resp_valid), 0);
        chk("mid_rst_r_en", 32'(core_r_enable), 1);
        rst = 1'b0;
        tick;
        chk("mid_post_busy", 32'(busy), 0);
        chk("mid_post_init_n", 32'(core_init_n), 0);
        seen = 0;
        pulses = 0;
        repeat (80) begin
            if (resp_valid) seen++;
            if (core_r_enable) pulses++;
            tick;
        end
        chk("mid_stale_resp", 32'(seen), 0);
        chk("mid_stale_start", 32'(pulses), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
